// File: rtl/cpu_bus_pkg.sv
// Shared types and address map for the CPU bus responder.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAM_RD,
    ST_IO_ACC,
    ST_IO_RD,
    ST_ROM_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO,
    REG_ROM,
    REG_NONE
  } region_t;

  localparam logic [15:0] IO_BASE  = 16'h2000;
  localparam logic [15:0] IO_LAST  = 16'h401F;
  localparam logic [15:0] ROM_BASE = 16'h8000;

  function automatic region_t decode_region(input logic [15:0] addr);
    if (addr[15:13] == 3'b000) return REG_RAM;
    if (addr >= ROM_BASE) return REG_ROM;
    if (addr >= IO_BASE && addr <= IO_LAST) return REG_IO;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// CPU-side, I/O-port and ROM-fetch signals of the bus responder.
interface cpu_bus_responder_if #(parameter int ROM_AW = 15);
  logic              cpu_req;
  logic              cpu_rw;
  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ready;
  logic              io_sel;
  logic              io_wr;
  logic [15:0]       io_addr;
  logic [7:0]        io_wdata;
  logic [7:0]        io_rdata;
  logic              rom_req;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_ack;
  logic [7:0]        rom_data;
  logic              bus_err;

  modport master (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata, io_rdata, rom_ack, rom_data,
    input  cpu_rdata, cpu_ready, io_sel, io_wr, io_addr, io_wdata,
           rom_req, rom_addr, bus_err
  );

  modport slave (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata, io_rdata, rom_ack, rom_data,
    output cpu_rdata, cpu_ready, io_sel, io_wr, io_addr, io_wdata,
           rom_req, rom_addr, bus_err
  );
endinterface

// File: rtl/wram_sp.sv
// Single-port synchronous work RAM, one-cycle read latency, contents not reset.
module wram_sp #(
  parameter int RAM_AW = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:(1<<RAM_AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU bus target: mirrored work RAM, I/O window, PRG ROM fetch with timeout.
// Optional OPEN_BUS_EN: unmapped reads return the last byte seen on the data bus.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int RAM_AW      = 11,
  parameter int ROM_AW      = 15,
  parameter int ROM_TIMEOUT = 16
) (
  input logic                clk,
  input logic                rst,
  cpu_bus_responder_if.slave bus
);

  localparam logic [7:0] TIMEOUT_INIT = 8'(ROM_TIMEOUT);

  state_t            state;
  region_t           region;
  logic              rw_q;
  logic [7:0]        cnt;
  logic [7:0]        cpu_rdata_q;
  logic              cpu_ready_q;
  logic              io_sel_q;
  logic              io_wr_q;
  logic [15:0]       io_addr_q;
  logic [7:0]        io_wdata_q;
  logic              rom_req_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic              bus_err_q;
  logic              ram_we;
  logic [7:0]        ram_rdata;
  logic [7:0]        open_bus;

`ifdef OPEN_BUS_EN
  logic [7:0] data_bus_q;
  assign open_bus = data_bus_q;
`else
  assign open_bus = '0;
`endif

  // RAM is addressed straight from the CPU bus so writes land on the accept edge
  // and reads have their data ready in RAM_RD.
  assign region = decode_region(bus.cpu_addr);
  assign ram_we = (state == ST_IDLE) && bus.cpu_req && (region == REG_RAM) && !bus.cpu_rw;

  wram_sp #(.RAM_AW(RAM_AW)) u_wram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (bus.cpu_addr[RAM_AW-1:0]),
    .wdata (bus.cpu_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      rw_q        <= 1'b0;
      cnt         <= '0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      io_sel_q    <= 1'b0;
      io_wr_q     <= 1'b0;
      io_addr_q   <= '0;
      io_wdata_q  <= '0;
      rom_req_q   <= 1'b0;
      rom_addr_q  <= '0;
      bus_err_q   <= 1'b0;
`ifdef OPEN_BUS_EN
      data_bus_q  <= '0;
`endif
    end else begin
      cpu_ready_q <= 1'b0;
      io_sel_q    <= 1'b0;
      io_wr_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cpu_req) begin
            rw_q       <= bus.cpu_rw;
            io_addr_q  <= bus.cpu_addr;
            io_wdata_q <= bus.cpu_wdata;
            case (region)
              REG_RAM: begin
                if (bus.cpu_rw) begin
                  state <= ST_RAM_RD;
                end else begin
                  cpu_ready_q <= 1'b1;
                  state       <= ST_DONE;
                end
              end
              REG_IO: begin
                io_sel_q <= 1'b1;
                io_wr_q  <= !bus.cpu_rw;
                state    <= ST_IO_ACC;
              end
              REG_ROM: begin
                if (bus.cpu_rw) begin
                  rom_req_q  <= 1'b1;
                  rom_addr_q <= bus.cpu_addr[ROM_AW-1:0];
                  cnt        <= TIMEOUT_INIT;
                  state      <= ST_ROM_WAIT;
                end else begin
                  bus_err_q   <= 1'b1;
                  cpu_ready_q <= 1'b1;
                  state       <= ST_DONE;
                end
              end
              default: begin
                if (bus.cpu_rw) cpu_rdata_q <= open_bus;
                cpu_ready_q <= 1'b1;
                state       <= ST_DONE;
              end
            endcase
          end
        end
        ST_RAM_RD: begin
          cpu_rdata_q <= ram_rdata;
          cpu_ready_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_IO_ACC: begin
          if (rw_q) begin
            state <= ST_IO_RD;
          end else begin
            cpu_ready_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_IO_RD: begin
          cpu_rdata_q <= bus.io_rdata;
          cpu_ready_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_ROM_WAIT: begin
          // An ack in the final counted cycle still wins over the timeout.
          if (bus.rom_ack) begin
            cpu_rdata_q <= bus.rom_data;
            rom_req_q   <= 1'b0;
            cpu_ready_q <= 1'b1;
            state       <= ST_DONE;
          end else if (cnt <= 8'd1) begin
            cpu_rdata_q <= 8'hFF;
            bus_err_q   <= 1'b1;
            rom_req_q   <= 1'b0;
            cpu_ready_q <= 1'b1;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_DONE: begin
`ifdef OPEN_BUS_EN
          data_bus_q <= rw_q ? cpu_rdata_q : io_wdata_q;
`endif
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.io_sel    = io_sel_q;
  assign bus.io_wr     = io_wr_q;
  assign bus.io_addr   = io_addr_q;
  assign bus.io_wdata  = io_wdata_q;
  assign bus.rom_req   = rom_req_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Randomised bench for cpu_bus_responder against a transaction-level memory-map model.
module tb_cpu_bus_responder;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  logic [7:0] m_ram [0:2047];
  logic [7:0] m_last_rd = 8'h00;
  logic [7:0] m_ob      = 8'h00;
  logic       m_berr    = 1'b0;

  always #5 clk = ~clk;

  cpu_bus_responder_if #(.ROM_AW(15)) bus ();

  cpu_bus_responder #(.RAM_AW(11), .ROM_AW(15), .ROM_TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 0 = RAM, 1 = IO, 2 = ROM, 3 = unmapped
  function automatic int region_of(input logic [15:0] a);
    int v = int'(a);
    if (v < 'h2000) return 0;
    if (v <= 'h401F) return 1;
    if (v >= 'h8000) return 2;
    return 3;
  endfunction

  task automatic access(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                        input int unsigned ack_dly, input logic [7:0] io_v,
                        input logic [7:0] rom_v);
    int r = region_of(addr);
    int unsigned exp_lat = 1;
    int unsigned exp_io = 0;
    int unsigned exp_rom = 0;
    logic [7:0] exp_rd = m_last_rd;
    int unsigned k = 0;
    int unsigned rom_cyc = 0;
    int unsigned io_cyc = 0;
    logic seen = 1'b0;

    case (r)
      0: begin
        exp_lat = rw ? 2 : 1;
        if (rw) exp_rd = m_ram[addr % 2048];
        else m_ram[addr % 2048] = wd;
      end
      1: begin
        exp_lat = rw ? 3 : 2;
        exp_io = 1;
        if (rw) exp_rd = io_v;
      end
      2: begin
        if (rw) begin
          if (ack_dly >= 1 && ack_dly <= TIMEOUT) begin
            exp_rom = ack_dly; exp_rd = rom_v; exp_lat = 1 + ack_dly;
          end else begin
            exp_rom = TIMEOUT; exp_rd = 8'hFF; exp_lat = 1 + TIMEOUT; m_berr = 1'b1;
          end
        end else begin
          m_berr = 1'b1;
        end
      end
      default: begin
`ifdef OPEN_BUS_EN
        if (rw) exp_rd = m_ob;
`else
        if (rw) exp_rd = 8'h00;
`endif
      end
    endcase
    m_ob = rw ? exp_rd : wd;
    m_last_rd = exp_rd;

    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_rw    = rw;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    bus.io_rdata  = io_v;
    bus.rom_ack   = (r != 2);
    bus.rom_data  = 8'hEE;

    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      k = i;
      bus.cpu_req   = 1'b0;
      bus.cpu_addr  = 16'($urandom);
      bus.cpu_wdata = 8'($urandom);
      if (bus.io_sel) begin
        io_cyc++;
        check("io_wr", 32'(bus.io_wr), 32'(!rw));
        check("io_addr", 32'(bus.io_addr), 32'(addr));
        check("io_wdata", 32'(bus.io_wdata), 32'(wd));
      end
      if (bus.rom_req) begin
        rom_cyc++;
        if (rom_cyc == 1) check("rom_addr", 32'(bus.rom_addr), 32'(addr[14:0]));
        bus.rom_ack  = (rom_cyc == ack_dly);
        bus.rom_data = rom_v;
      end else if (r == 2) begin
        bus.rom_ack = 1'b0;
      end
      if (bus.cpu_ready) begin
        seen = 1'b1;
        break;
      end
    end
    bus.rom_ack = 1'b0;

    check("ready_seen", 32'(seen), 32'd1);
    check("latency", k, exp_lat);
    check("rdata", 32'(bus.cpu_rdata), 32'(exp_rd));
    check("bus_err", 32'(bus.bus_err), 32'(m_berr));
    check("io_sel_cycles", io_cyc, exp_io);
    check("rom_req_cycles", rom_cyc, exp_rom);

    @(negedge clk);
    check("ready_pulse", 32'(bus.cpu_ready), 32'd0);
    check("rdata_hold", 32'(bus.cpu_rdata), 32'(exp_rd));
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_rw = 1'b1; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.io_rdata = '0; bus.rom_ack = 1'b0; bus.rom_data = '0;
    for (int i = 0; i < 2048; i++) m_ram[i] = 8'hxx;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.cpu_ready), 32'd0);
    check("rst_rdata", 32'(bus.cpu_rdata), 32'h00);
    check("rst_io_sel", 32'(bus.io_sel), 32'd0);
    check("rst_rom_req", 32'(bus.rom_req), 32'd0);
    check("rst_bus_err", 32'(bus.bus_err), 32'd0);
    check("rst_io_addr", 32'(bus.io_addr), 32'd0);
    rst = 1'b1;

    access(1'b0, 16'h0005, 8'hA5, 0, 8'h00, 8'h00);
    access(1'b1, 16'h0805, 8'h00, 0, 8'h00, 8'h00);
    access(1'b1, 16'h8123, 8'h00, 4, 8'h00, 8'h3C);
    access(1'b0, 16'h2006, 8'h21, 0, 8'h00, 8'h00);
    access(1'b1, 16'h4016, 8'h00, 0, 8'h41, 8'h00);
    access(1'b0, 16'h0010, 8'h5A, 0, 8'h00, 8'h00);
    access(1'b1, 16'h5000, 8'h00, 0, 8'h00, 8'h00);
    access(1'b1, 16'hC000, 8'h00, 99, 8'h00, 8'h00);
    access(1'b1, 16'hC001, 8'h00, TIMEOUT, 8'h00, 8'h77);
    access(1'b0, 16'h9000, 8'h33, 0, 8'h00, 8'h00);

    // Reset in the middle of a ROM fetch.
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 16'hA000;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rom_req", 32'(bus.rom_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_rom_req", 32'(bus.rom_req), 32'd0);
    check("mid_rst_ready", 32'(bus.cpu_ready), 32'd0);
    check("mid_rst_bus_err", 32'(bus.bus_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_berr = 1'b0; m_last_rd = 8'h00; m_ob = 8'h00;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_ready", 32'(bus.cpu_ready), 32'd0);
    end
    access(1'b1, 16'h0005, 8'h00, 0, 8'h00, 8'h00);

    for (int n = 0; n < 80; n++) begin
      logic [15:0] a;
      case ($urandom_range(0, 3))
        0: a = 16'($urandom_range(16'h0000, 16'h1FFF));
        1: a = 16'($urandom_range(16'h2000, 16'h401F));
        2: a = 16'h8000 | 16'($urandom);
        default: a = 16'($urandom_range(16'h4020, 16'h7FFF));
      endcase
      // Reads of never-written RAM have no defined value; write those first.
      if (region_of(a) == 0 && m_ram[a % 2048] === 8'hxx)
        access(1'b0, a, 8'($urandom), 0, 8'h00, 8'h00);
      access(1'($urandom), a, 8'($urandom), $urandom_range(1, 20),
             8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
